// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the memory copy/fill engine.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    FILL_WR  = 3'd4,
    FILL_GAP = 3'd5,
    FINISH   = 3'd6
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte copy/fill engine driving a synchronous single-port memory.
// Copy takes 3 cycles per byte (address, read wait, write); fill takes 2 (write, gap).
module mem_copy_engine
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // Request: start is accepted only in IDLE; busy rises the cycle after
  // acceptance and falls together with the single-cycle done pulse.
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        length,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        remaining,
  output logic [2:0]        dbg_state
);

  state_t              r_state, w_nxt_state;
  logic [ADDR_W-1:0]   r_src, w_nxt_src;
  logic [ADDR_W-1:0]   r_dst, w_nxt_dst;
  logic [7:0]          r_rem, w_nxt_rem;
  logic [ADDR_W-1:0]   r_addr, w_nxt_addr;
  logic [DATA_W-1:0]   r_wdata, w_nxt_wdata;
  logic                r_we, w_nxt_we;
  logic                r_busy, w_nxt_busy;
  logic                r_done, w_nxt_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_src   <= w_nxt_src;
      r_dst   <= w_nxt_dst;
      r_rem   <= w_nxt_rem;
      r_addr  <= w_nxt_addr;
      r_wdata <= w_nxt_wdata;
      r_we    <= w_nxt_we;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  // All memory-side outputs are registered: each branch sets what the
  // memory must see during the state being entered.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_src   = r_src;
    w_nxt_dst   = r_dst;
    w_nxt_rem   = r_rem;
    w_nxt_addr  = r_addr;
    w_nxt_wdata = r_wdata;
    w_nxt_we    = 1'b0;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_busy = 1'b1;
          w_nxt_src  = src_addr;
          w_nxt_dst  = dst_addr;
          w_nxt_rem  = length;
          if (length == 8'd0) begin
            w_nxt_state = FINISH;
          end else if (mode) begin
            w_nxt_state = FILL_WR;
            w_nxt_addr  = dst_addr;
            w_nxt_wdata = fill_value;
            w_nxt_we    = 1'b1;
          end else begin
            w_nxt_state = RD_ADDR;
            w_nxt_addr  = src_addr;
          end
        end
      end
      RD_ADDR: begin
        w_nxt_state = RD_WAIT;
      end
      RD_WAIT: begin
        w_nxt_state = WR;
        w_nxt_addr  = r_dst;
        w_nxt_wdata = mem_data_out;
        w_nxt_we    = 1'b1;
      end
      WR: begin
        w_nxt_src = r_src + 8'd1;
        w_nxt_dst = r_dst + 8'd1;
        w_nxt_rem = r_rem - 8'd1;
        if (r_rem != 8'd1) begin
          w_nxt_state = RD_ADDR;
          w_nxt_addr  = r_src + 8'd1;
        end else begin
          w_nxt_state = FINISH;
        end
      end
      FILL_WR: begin
        w_nxt_state = FILL_GAP;
        w_nxt_dst   = r_dst + 8'd1;
        w_nxt_rem   = r_rem - 8'd1;
      end
      FILL_GAP: begin
        if (r_rem != 8'd0) begin
          w_nxt_state = FILL_WR;
          w_nxt_addr  = r_dst;
          w_nxt_we    = 1'b1;
        end else begin
          w_nxt_state = FINISH;
        end
      end
      FINISH: begin
        w_nxt_done  = 1'b1;
        w_nxt_busy  = 1'b0;
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  assign mem_address      = r_addr;
  assign mem_data_in      = r_wdata;
  assign mem_write_enable = r_we;
  assign busy             = r_busy;
  assign done             = r_done;
  assign remaining        = r_rem;
  assign dbg_state        = r_state;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: start  input  1  one-cycle request pulse, sampled in IDLE only.
REQ-004 SHALL expose: mode  input  1  0 = copy, 1 = fill; sampled with start.
REQ-005 SHALL expose: src_addr  input  8  copy source base; sampled with start.
REQ-006 SHALL expose: dst_addr  input  8  destination base; sampled with start.
REQ-007 SHALL expose: length  input  8  byte count; 0 = no transfer; sampled with start.
REQ-008 SHALL expose: fill_value  input  8  byte written in fill mode; sampled with start.
REQ-009 SHALL expose: mem_address  output  8  address to memory, registered.
REQ-010 SHALL expose: mem_data_in  output  8  write data to memory, registered.
REQ-011 SHALL expose: mem_write_enable  output  1  memory write strobe, registered.
REQ-012 SHALL expose: mem_data_out  input  8  memory read data, valid one rising edge after address sampled.
REQ-013 SHALL expose: busy  output  1  high from the cycle after accepted start until done.
REQ-014 SHALL expose: done  output  1  one-cycle pulse at transfer end.
REQ-015 SHALL expose: remaining  output  8  bytes not yet written.

Function
REQ-016 States SHALL be IDLE, RD_ADDR, RD_WAIT, WR, FILL_WR, FILL_GAP, FINISH.
REQ-017 IDLE + start + length!=0 + mode=0 SHALL go RD_ADDR, mem_address=src_addr, remaining=length.
REQ-018 IDLE + start + length!=0 + mode=1 SHALL go FILL_WR, mem_address=dst_addr, mem_data_in=fill_value, mem_write_enable=1.
REQ-019 IDLE + start + length=0 SHALL go FINISH; no memory write occurs.
REQ-020 RD_ADDR SHALL go RD_WAIT with mem_write_enable=0 (memory registers read data this edge).
REQ-021 RD_WAIT SHALL capture mem_data_out, go WR, drive mem_address=dst pointer, mem_data_in=captured byte, mem_write_enable=1.
REQ-022 WR SHALL last exactly one cycle; leaving it, remaining decrements, both pointers increment, mem_write_enable=0.
REQ-023 After WR, remaining!=0 SHALL go RD_ADDR with mem_address=next src pointer; else FINISH.
REQ-024 Copy throughput SHALL be exactly 3 cycles per byte; fill SHALL be 2 cycles per byte (FILL_WR strobe, FILL_GAP strobe low).
REQ-025 FILL_GAP SHALL go FILL_WR with next dst pointer if remaining!=0, else FINISH.
REQ-026 FINISH SHALL pulse done for one cycle, drop busy, return IDLE.
REQ-027 Pointers SHALL wrap modulo 256 (0xFF+1 = 0x00).
REQ-028 Copy SHALL run ascending; overlapping regions with dst>src are not protected (source overwrite is permitted behaviour).
REQ-029 start while not IDLE SHALL be ignored; captured parameters unaffected.
REQ-030 mem_write_enable SHALL never be high outside WR/FILL_WR and never two consecutive cycles.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, mem_write_enable=0, busy=0, done=0, mem_address=0, mem_data_in=0, remaining=0.
REQ-032 Reset mid-transfer SHALL abort without done; bytes already written remain; no partial write after reset assertion.

Structure
REQ-033 Shared package mem_pkg SHALL hold ADDR_W=8, DATA_W=8 and the state enumeration.
REQ-034 Single module; no sub-module; pointers and counter inline.

Verification
REQ-035 Copy src=0x10,dst=0x80,len=4, mem[0x10..0x13]=A1,B2,C3,D4 -> mem[0x80..0x83]=A1,B2,C3,D4; done 13 cycles after start.
REQ-036 Fill dst=0x20,len=3,fill=0x5A -> mem[0x20..0x22]=5A, mem[0x23] unchanged; strobe pattern 1,0,1,0,1,0.
REQ-037 len=0 -> done one cycle after busy, mem_write_enable never asserted.
REQ-038 Copy src=0xFE,dst=0x40,len=3 -> reads 0xFE,0xFF,0x00; writes 0x40..0x42.
REQ-039 rst_n low during second WR of len=4 copy -> strobe low immediately, busy=0, no done, only first byte written.
REQ-040 start re-pulsed mid-copy with different params -> ignored; original transfer completes unchanged.
